// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared timing constants and counter-width helper for the VGA timing generator.
//   Provides 640x480@60 (25.175 MHz) and 800x600@72 (50 MHz) timing sets and
//   min_width(), the smallest counter width able to hold 0..total-1.
package vga_timing_pkg;

   localparam int VGA640_H_ACTIVE = 640;
   localparam int VGA640_H_FP     = 16;
   localparam int VGA640_H_SYNC   = 96;
   localparam int VGA640_H_BP     = 48;
   localparam int VGA640_V_ACTIVE = 480;
   localparam int VGA640_V_FP     = 10;
   localparam int VGA640_V_SYNC   = 2;
   localparam int VGA640_V_BP     = 33;
   localparam bit VGA640_H_POL    = 1'b0;
   localparam bit VGA640_V_POL    = 1'b0;

   localparam int SVGA800_H_ACTIVE = 800;
   localparam int SVGA800_H_FP     = 56;
   localparam int SVGA800_H_SYNC   = 120;
   localparam int SVGA800_H_BP     = 64;
   localparam int SVGA800_V_ACTIVE = 600;
   localparam int SVGA800_V_FP     = 37;
   localparam int SVGA800_V_SYNC   = 6;
   localparam int SVGA800_V_BP     = 23;
   localparam bit SVGA800_H_POL    = 1'b1;
   localparam bit SVGA800_V_POL    = 1'b1;

   function automatic int min_width(input int total);
      int w;
      w = 1;
      while ((1 << w) < total) w++;
      return w;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (horizontal or vertical) -- counter plus sync/active decode.
//   clk, rst_n : clock, asynchronous active-low reset
//   tick_i     : advance the count by one
//   count_o    : current count 0..TOTAL-1
//   sync_o     : sync level for the current count, polarity POL
//   active_o   : count lies in the visible region
//   wrap_o     : tick_i while at TOTAL-1 (count returns to 0 on this tick)
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE = VGA640_H_ACTIVE,
   parameter int FP     = VGA640_H_FP,
   parameter int SYNC   = VGA640_H_SYNC,
   parameter int BP     = VGA640_H_BP,
   parameter bit POL    = 1'b0,
   parameter int W      = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         tick_i,
   output logic [W-1:0] count_o,
   output logic         sync_o,
   output logic         active_o,
   output logic         wrap_o
);

   localparam int TOTAL = ACTIVE + FP + SYNC + BP;

   logic [W-1:0] cnt_q, cnt_d;
   logic         in_sync;

   assign wrap_o   = tick_i && (cnt_q == W'(TOTAL - 1));
   assign cnt_d    = wrap_o ? '0 : cnt_q + W'(1);
   assign in_sync  = (cnt_q >= W'(ACTIVE + FP)) && (cnt_q < W'(ACTIVE + FP + SYNC));
   assign sync_o   = in_sync ? POL : ~POL;
   assign active_o = cnt_q < W'(ACTIVE);
   assign count_o  = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else if (tick_i) cnt_q <= cnt_d;
   end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator with clock-enable pixel divider.
//   clk, rst_n     : system clock, asynchronous active-low reset
//   x_o, y_o       : registered pixel coordinates, one pixel update behind the internal counters
//   h_sync_o       : horizontal sync, polarity H_SYNC_POL
//   v_sync_o       : vertical sync, polarity V_SYNC_POL
//   frame_active_o : x_o < H_ACTIVE and y_o < V_ACTIVE
//   pix_stb_o      : one-clk pulse when the outputs take a new pixel
//   line_start_o   : pix_stb_o with x_o = 0
//   frame_start_o  : pix_stb_o with x_o = 0 and y_o = 0
//   frame_cnt_o    : 8-bit frame counter, present only when VGA_FRAME_CNT_EN is defined
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE   = VGA640_H_ACTIVE,
   parameter int H_FP       = VGA640_H_FP,
   parameter int H_SYNC     = VGA640_H_SYNC,
   parameter int H_BP       = VGA640_H_BP,
   parameter int V_ACTIVE   = VGA640_V_ACTIVE,
   parameter int V_FP       = VGA640_V_FP,
   parameter int V_SYNC     = VGA640_V_SYNC,
   parameter int V_BP       = VGA640_V_BP,
   parameter bit H_SYNC_POL = VGA640_H_POL,
   parameter bit V_SYNC_POL = VGA640_V_POL,
   parameter int CLK_DIV    = 1,
   parameter int XW         = 10,
   parameter int YW         = 10
) (
   input  logic          clk,
   input  logic          rst_n,
`ifdef VGA_FRAME_CNT_EN
   output logic [7:0]    frame_cnt_o,
`endif
   output logic [XW-1:0] x_o,
   output logic [YW-1:0] y_o,
   output logic          h_sync_o,
   output logic          v_sync_o,
   output logic          frame_active_o,
   output logic          pix_stb_o,
   output logic          line_start_o,
   output logic          frame_start_o
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (XW < min_width(H_TOTAL) || YW < min_width(V_TOTAL)) begin : g_bad_width
      $error("vga_timing_gen: XW/YW too narrow for the timing totals");
   end
   if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be 1..16");
   end
   if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
      $error("vga_timing_gen: porch and sync widths must be at least 1");
   end

   logic [3:0]    div_q, div_d;
   logic          ce;
   logic [XW-1:0] h_cnt;
   logic [YW-1:0] v_cnt;
   logic          h_sync, v_sync, h_act, v_act, h_wrap, v_wrap;
   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;
   logic          hs_q, vs_q, fa_q, pix_stb_q, line_start_q, frame_start_q;
   logic          origin_q;

   // With CLK_DIV=1 div_q never leaves 0, so ce is constantly high.
   assign ce    = div_q == 4'(CLK_DIV - 1);
   assign div_d = ce ? 4'd0 : div_q + 4'd1;

   vga_axis_counter #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_SYNC_POL), .W(XW)
   ) u_h (
      .clk(clk), .rst_n(rst_n), .tick_i(ce),
      .count_o(h_cnt), .sync_o(h_sync), .active_o(h_act), .wrap_o(h_wrap)
   );

   vga_axis_counter #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_SYNC_POL), .W(YW)
   ) u_v (
      .clk(clk), .rst_n(rst_n), .tick_i(h_wrap),
      .count_o(v_cnt), .sync_o(v_sync), .active_o(v_act), .wrap_o(v_wrap)
   );

   // origin_q marks the internal counters sitting at (0,0): true out of reset and after the frame wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q         <= '0;
         x_q           <= '0;
         y_q           <= '0;
         hs_q          <= ~H_SYNC_POL;
         vs_q          <= ~V_SYNC_POL;
         fa_q          <= 1'b0;
         pix_stb_q     <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         origin_q      <= 1'b1;
      end else begin
         div_q         <= div_d;
         pix_stb_q     <= ce;
         line_start_q  <= ce && (h_cnt == '0);
         frame_start_q <= ce && origin_q;
         if (ce) begin
            x_q      <= h_cnt;
            y_q      <= v_cnt;
            hs_q     <= h_sync;
            vs_q     <= v_sync;
            fa_q     <= h_act && v_act;
            origin_q <= v_wrap;
         end
      end
   end

   assign x_o            = x_q;
   assign y_o            = y_q;
   assign h_sync_o       = hs_q;
   assign v_sync_o       = vs_q;
   assign frame_active_o = fa_q;
   assign pix_stb_o      = pix_stb_q;
   assign line_start_o   = line_start_q;
   assign frame_start_o  = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
   logic [7:0] frame_cnt_q;
   logic       first_q;

   // The first frame after reset is frame 0, so its start only clears first_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
         first_q     <= 1'b1;
      end else if (ce && origin_q) begin
         first_q <= 1'b0;
         if (!first_q) frame_cnt_q <= frame_cnt_q + 8'd1;
      end
   end

   assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized-reset check of two vga_timing_gen configurations against an arithmetic pixel model.
module tb_vga_timing_gen;

   typedef struct packed {
      int x;
      int y;
      bit hs;
      bit vs;
      bit fa;
      bit ps;
      bit ls;
      bit fs;
      int fc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_edges;
   int   n_checks;
   int   n_errors;

   logic [2:0] x_a, y_a;
   logic       hs_a, vs_a, fa_a, ps_a, ls_a, fs_a;
   logic [4:0] x_b;
   logic [3:0] y_b;
   logic       hs_b, vs_b, fa_b, ps_b, ls_b, fs_b;
`ifdef VGA_FRAME_CNT_EN
   logic [7:0] fc_a, fc_b;
`endif

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CLK_DIV(1), .XW(3), .YW(3)
   ) dut_a (
      .clk(clk), .rst_n(rst_n),
`ifdef VGA_FRAME_CNT_EN
      .frame_cnt_o(fc_a),
`endif
      .x_o(x_a), .y_o(y_a), .h_sync_o(hs_a), .v_sync_o(vs_a), .frame_active_o(fa_a),
      .pix_stb_o(ps_a), .line_start_o(ls_a), .frame_start_o(fs_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .CLK_DIV(3), .XW(5), .YW(4)
   ) dut_b (
      .clk(clk), .rst_n(rst_n),
`ifdef VGA_FRAME_CNT_EN
      .frame_cnt_o(fc_b),
`endif
      .x_o(x_b), .y_o(y_b), .h_sync_o(hs_b), .v_sync_o(vs_b), .frame_active_o(fa_b),
      .pix_stb_o(ps_b), .line_start_o(ls_b), .frame_start_o(fs_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rising edges seen with reset released; the model is a pure function of this count.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) n_edges <= 0;
      else n_edges <= n_edges + 1;
   end

   function automatic exp_t model(input int n, input int div,
                                  input int ha, input int hf, input int hsy, input int hb,
                                  input int va, input int vf, input int vsy, input int vb,
                                  input bit hp, input bit vp);
      exp_t e;
      int   ht, vt, u, p;
      ht   = ha + hf + hsy + hb;
      vt   = va + vf + vsy + vb;
      u    = n / div;
      e    = '0;
      e.hs = ~hp;
      e.vs = ~vp;
      if (u > 0) begin
         p    = (u - 1) % (ht * vt);
         e.x  = p % ht;
         e.y  = p / ht;
         e.hs = (e.x >= ha + hf && e.x < ha + hf + hsy) ? hp : ~hp;
         e.vs = (e.y >= va + vf && e.y < va + vf + vsy) ? vp : ~vp;
         e.fa = e.x < ha && e.y < va;
         e.ps = (n % div) == 0;
         e.ls = e.ps && e.x == 0;
         e.fs = e.ls && e.y == 0;
         e.fc = ((u - 1) / (ht * vt)) % 256;
      end
      return e;
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", tag, n_edges, got, exp);
      end
   endtask

   task automatic check_all();
      exp_t ea, eb;
      ea = model(n_edges, 1, 4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1);
      eb = model(n_edges, 3, 16, 2, 3, 4, 6, 1, 2, 3, 1'b1, 1'b0);
      check("a.x", int'(x_a), ea.x);
      check("a.y", int'(y_a), ea.y);
      check("a.h_sync", int'(hs_a), int'(ea.hs));
      check("a.v_sync", int'(vs_a), int'(ea.vs));
      check("a.frame_active", int'(fa_a), int'(ea.fa));
      check("a.pix_stb", int'(ps_a), int'(ea.ps));
      check("a.line_start", int'(ls_a), int'(ea.ls));
      check("a.frame_start", int'(fs_a), int'(ea.fs));
      check("b.x", int'(x_b), eb.x);
      check("b.y", int'(y_b), eb.y);
      check("b.h_sync", int'(hs_b), int'(eb.hs));
      check("b.v_sync", int'(vs_b), int'(eb.vs));
      check("b.frame_active", int'(fa_b), int'(eb.fa));
      check("b.pix_stb", int'(ps_b), int'(eb.ps));
      check("b.line_start", int'(ls_b), int'(eb.ls));
      check("b.frame_start", int'(fs_b), int'(eb.fs));
`ifdef VGA_FRAME_CNT_EN
      check("a.frame_cnt", int'(fc_a), ea.fc);
      check("b.frame_cnt", int'(fc_b), eb.fc);
`endif
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check_all();
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      run(3);
      rst_n = 1'b1;
      run(int'($urandom_range(400, 900)));
      // Mid-frame reset asserted between edges: outputs must clear without any clock edge.
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_all();
      run(2);
      rst_n = 1'b1;
      // Long enough for dut_a (35 pixels/frame) to pass 256 frame starts and wrap frame_cnt.
      run(9100 + int'($urandom_range(0, 60)));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
